shift_engine: RTL and testbench

- Parametrised serial shift engine, generalising the fixed 8-bit SIPO register to a full-duplex shifter.
- Loads a parallel word and shifts it out on sdo while capturing sdi.
- Supports a programmable bit count (1..WIDTH) and MSB- or LSB-first order.
- Raises a done pulse and presents the right-aligned received word on a latched parallel output; used by the SWD datapath for request/ack/data phases.

---
 rtl/shift_pkg.sv | 14 +
 rtl/shift_engine.sv | 93 +++++++++
 tb/tb_shift_engine.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared types and helpers for the serial shift engine.
package shift_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // A requested count of 0, or one larger than the register, means a full-width transfer.
  function automatic int unsigned eff_nbits(input int unsigned nbits, input int unsigned width);
    return ((nbits == 0) || (nbits > width)) ? width : nbits;
  endfunction

endpackage

// File: rtl/shift_engine.sv
// Full-duplex serial shift engine: parallel load, shift out on sdo while capturing sdi,
// programmable length and bit order, done pulse with right-aligned received word on q.
module shift_engine
  import shift_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [WIDTH-1:0] load_data,
  input  logic [CNT_W-1:0] nbits,
  input  logic             lsb_first,
  input  logic             tick,
  input  logic             sdi,
  output logic             sdo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] ONES = '1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d, shifted;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, n_q, n_d;
  logic             lsb_q, lsb_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      n_q     <= '0;
      lsb_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      lsb_q   <= lsb_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    lsb_d   = lsb_q;
    done_d  = 1'b0;
    shifted = lsb_q ? {sdi, shreg_q[WIDTH-1:1]} : {shreg_q[WIDTH-2:0], sdi};

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          shreg_d = load_data;
          cnt_d   = CNT_W'(eff_nbits(32'(nbits), WIDTH));
          n_d     = CNT_W'(eff_nbits(32'(nbits), WIDTH));
          lsb_d   = lsb_first;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          shreg_d = shifted;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            // LSB-first data enters at the top, so right-align by shifting down.
            q_d     = lsb_q ? (shifted >> (WIDTH - 32'(n_q))) : (shifted & ~(ONES << n_q));
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign sdo  = lsb_q ? shreg_q[0] : shreg_q[WIDTH-1];
  assign busy = (state_q == ST_SHIFT);
  assign done = done_q;
  assign q    = q_q;

endmodule

// File: tb/tb_shift_engine.sv
// Directed self-checking bench for shift_engine at WIDTH=8.
module tb_shift_engine;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] load_data = '0;
  logic [3:0] nbits = '0;
  logic       lsb_first = 1'b0;
  logic       tick = 1'b0;
  logic       sdi = 1'b0;
  logic       sdo, busy, done;
  logic [7:0] q;

  int unsigned checks = 0;
  int unsigned failures = 0;

  shift_engine #(.WIDTH(8)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .start     (start),
    .load_data (load_data),
    .nbits     (nbits),
    .lsb_first (lsb_first),
    .tick      (tick),
    .sdi       (sdi),
    .sdo       (sdo),
    .busy      (busy),
    .done      (done),
    .q         (q)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One transfer; returns in the done cycle (or one cycle later when chain=0).
  task automatic xfer(input string tag, input logic [7:0] ld, input logic [3:0] nb,
                      input logic lsb, input logic [7:0] w, input int gap, input bit poke,
                      input bit started, input logic [7:0] q_hold, input logic [7:0] exp_q,
                      input bit chain);
    int n;
    n = (nb == 0 || nb > 8) ? 8 : int'(nb);
    if (!started) begin
      start = 1'b1; load_data = ld; nbits = nb; lsb_first = lsb;
      cyc();
      start = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      check_val({tag, "_sdo"}, 32'(sdo), 32'(lsb ? ld[i] : ld[7-i]));
      check_val({tag, "_busy"}, 32'(busy), 32'd1);
      check_val({tag, "_nodone"}, 32'(done), 32'd0);
      check_val({tag, "_qhold"}, 32'(q), 32'(q_hold));
      sdi = lsb ? w[i] : w[n-1-i];
      for (int g = 1; g < gap; g++) begin
        tick = 1'b0;
        if (poke && i == 2 && g == 1) begin
          start = 1'b1; load_data = 8'h00; nbits = 4'd1; lsb_first = 1'b1;
        end
        cyc();
        start = 1'b0;
        check_val({tag, "_gap_busy"}, 32'(busy), 32'd1);
        check_val({tag, "_gap_done"}, 32'(done), 32'd0);
      end
      tick = 1'b1;
      cyc();
    end
    check_val({tag, "_done"}, 32'(done), 32'd1);
    check_val({tag, "_busy_end"}, 32'(busy), 32'd0);
    check_val({tag, "_q"}, 32'(q), 32'(exp_q));
    if (!chain) begin
      cyc();
      check_val({tag, "_pulse"}, 32'(done), 32'd0);
      check_val({tag, "_q_after"}, 32'(q), 32'(exp_q));
    end
  endtask

  initial begin
    // Reset while idle
    #2;
    check_val("rst_q", 32'(q), 32'h00);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_sdo", 32'(sdo), 32'd0);
    cyc(); cyc();
    clr_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      check_val("post_rst_busy", 32'(busy), 32'd0);
      check_val("post_rst_done", 32'(done), 32'd0);
      check_val("post_rst_q", 32'(q), 32'h00);
    end

    tick = 1'b1;
    xfer("msb8", 8'hA5, 4'd8, 1'b0, 8'h3C, 1, 1'b0, 1'b0, 8'h00, 8'h3C, 1'b0);
    xfer("lsb3", 8'h05, 4'd3, 1'b1, 8'h03, 1, 1'b0, 1'b0, 8'h3C, 8'h03, 1'b0);
    xfer("gap", 8'hF0, 4'd8, 1'b0, 8'hFF, 3, 1'b1, 1'b0, 8'h03, 8'hFF, 1'b0);

    // nbits=0 means full width, then a start accepted in the done cycle
    tick = 1'b1;
    xfer("nb0", 8'hC3, 4'd0, 1'b0, 8'h5A, 1, 1'b0, 1'b0, 8'hFF, 8'h5A, 1'b1);
    start = 1'b1; load_data = 8'h81; nbits = 4'd8; lsb_first = 1'b0;
    cyc();
    start = 1'b0;
    check_val("b2b_busy", 32'(busy), 32'd1);
    check_val("b2b_nodone", 32'(done), 32'd0);
    check_val("b2b_qhold", 32'(q), 32'h5A);
    xfer("b2b", 8'h81, 4'd8, 1'b0, 8'h3F, 1, 1'b0, 1'b1, 8'h5A, 8'h3F, 1'b0);

    // Reset mid-transfer
    start = 1'b1; load_data = 8'hFF; nbits = 4'd8; lsb_first = 1'b0; tick = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 4; k++) cyc();
    check_val("mid_busy_pre", 32'(busy), 32'd1);
    check_val("mid_sdo_pre", 32'(sdo), 32'd1);
    clr_n = 1'b0;
    #1;
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    check_val("mid_rst_q", 32'(q), 32'h00);
    check_val("mid_rst_sdo", 32'(sdo), 32'd0);
    check_val("mid_rst_done", 32'(done), 32'd0);
    cyc();
    clr_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      check_val("mid_rst_nodone", 32'(done), 32'd0);
      check_val("mid_rst_idle", 32'(busy), 32'd0);
    end
    xfer("after_rst", 8'h5A, 4'd8, 1'b0, 8'h0F, 1, 1'b0, 1'b0, 8'h00, 8'h0F, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
